hs_source: RTL and testbench

Handshake stream source: the transmitting end of the valid/ready word interface that feeds the RAM handshake buffer (`bus`) on its `a_` side. On a `start` pulse it emits a burst of `len` words (counting or 32-bit LFSR pattern) with a programmable idle gap between beats. It obeys the stall rule the buffer relies on, so the buffer can be exercised in-system and by benches without hand-written stimulus.

---
 rtl/hs_pkg.sv | 23 ++
 rtl/hs_lfsr32.sv | 37 +++
 rtl/hs_source.sv | 151 +++++++++++++++
 tb/tb_hs_source.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hs_pkg.sv
// Shared types and constants for the handshake stream source.
package hs_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSend,
    StGap,
    StDone
  } hs_state_e;

  // Galois feedback taps for the 32-bit right-shifting LFSR
  localparam logic [31:0] LFSR_TAPS    = 32'h8020_0003;
  localparam logic [31:0] DEFAULT_SEED = 32'h0000_0001;

  // One LFSR step: shift right, fold taps back in when a one falls out
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    logic [31:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ LFSR_TAPS;
    return n;
  endfunction

endpackage

// File: rtl/hs_lfsr32.sv
// 32-bit Galois LFSR pattern generator with synchronous seed load and step enable.
module hs_lfsr32
  import hs_pkg::*;
#(
  parameter logic [31:0] SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        adv,
  output logic [31:0] q
);

  logic [31:0] q_q, q_d;

  // Load has priority so a burst restart never sees a stale step
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = SEED;
    end else if (adv) begin
      q_d = lfsr_next(q_q);
    end
  end

  // LFSR state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= SEED;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/hs_source.sv
// Valid/ready burst source: emits len words (counting or LFSR) with an optional idle
// gap between beats, holding valid/data stable across downstream stalls.
module hs_source
  import hs_pkg::*;
#(
  parameter int unsigned DATABIT = 32,
  parameter int unsigned LEN_BIT = 8,
  parameter logic [31:0] SEED    = DEFAULT_SEED
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [LEN_BIT-1:0] len,
  input  logic [3:0]         gap,
  input  logic               mode,
  output logic [DATABIT-1:0] out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               done,
  output logic [LEN_BIT-1:0] beat_cnt
);

  hs_state_e          state_q, state_d;
  logic [LEN_BIT-1:0] len_q, len_d;
  logic [LEN_BIT-1:0] beat_cnt_q, beat_cnt_d;
  logic [LEN_BIT-1:0] beat_inc;
  logic [3:0]         gap_q, gap_d;
  logic [3:0]         gap_cnt_q, gap_cnt_d;
  logic               mode_q, mode_d;
  logic [31:0]        cnt_q, cnt_d;
  logic [31:0]        lfsr_w;
  logic [31:0]        pat_w;
  logic               start_acc;
  logic               accept;
  logic               last_beat;

  assign start_acc = start && (state_q == StIdle);
  // out_valid is exactly "in SEND", so acceptance needs only the state and ready
  assign accept    = (state_q == StSend) && out_ready;
  assign beat_inc  = beat_cnt_q + LEN_BIT'(1);
  assign last_beat = (beat_inc == len_q);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = (len != '0) ? StSend : StDone;
        end
      end
      StSend: begin
        if (accept) begin
          if (last_beat) begin
            state_d = StDone;
          end else if (gap_q != 4'd0) begin
            state_d = StGap;
          end
        end
      end
      StGap: begin
        if (gap_cnt_q == 4'd1) begin
          state_d = StSend;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State-decoded outputs; ready never feeds into valid
  always_comb begin
    out_valid = (state_q == StSend);
    busy      = (state_q != StIdle);
    done      = (state_q == StDone);
  end

  // Burst configuration, beat counter, gap counter and counting pattern next-state
  always_comb begin
    len_d      = len_q;
    gap_d      = gap_q;
    mode_d     = mode_q;
    beat_cnt_d = beat_cnt_q;
    cnt_d      = cnt_q;
    gap_cnt_d  = gap_cnt_q;
    if (start_acc) begin
      len_d      = len;
      gap_d      = gap;
      mode_d     = mode;
      beat_cnt_d = '0;
      cnt_d      = '0;
    end else if (accept) begin
      beat_cnt_d = beat_inc;
      cnt_d      = cnt_q + 32'd1;
      if (!last_beat) begin
        gap_cnt_d = gap_q;
      end
    end else if (state_q == StGap) begin
      gap_cnt_d = gap_cnt_q - 4'd1;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q      <= '0;
      gap_q      <= '0;
      mode_q     <= 1'b0;
      beat_cnt_q <= '0;
      cnt_q      <= '0;
      gap_cnt_q  <= '0;
    end else begin
      len_q      <= len_d;
      gap_q      <= gap_d;
      mode_q     <= mode_d;
      beat_cnt_q <= beat_cnt_d;
      cnt_q      <= cnt_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

  hs_lfsr32 #(
    .SEED(SEED)
  ) u_lfsr (
    .clk (clk),
    .rst (rst),
    .load(start_acc),
    .adv (accept),
    .q   (lfsr_w)
  );

  // Pattern select; data is shown in every state but only meaningful under valid
  always_comb begin
    pat_w    = mode_q ? lfsr_w : cnt_q;
    out_data = pat_w[DATABIT-1:0];
    beat_cnt = beat_cnt_q;
  end

endmodule

// File: tb/tb_hs_source.sv
module tb_hs_source;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  len;
  logic [3:0]  gap;
  logic        mode;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;
  logic [7:0]  beat_cnt;

  int checks = 0;
  int errors = 0;

  hs_source dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .len      (len),
    .gap      (gap),
    .mode     (mode),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy),
    .done     (done),
    .beat_cnt (beat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference LFSR: halve the state, and if it was odd fold in the tap word
  function automatic logic [31:0] ref_lfsr(input logic [31:0] s);
    logic [31:0] h;
    h = s / 2;
    if ((s % 2) == 1) h = h ^ 32'h8020_0003;
    return h;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  // Pulse start across one rising edge; returns at the negedge after that edge
  task automatic do_start(input logic [7:0] l, input logic [3:0] g, input logic m);
    start = 1'b1;
    len   = l;
    gap   = g;
    mode  = m;
    tick();
    start = 1'b0;
    len   = $urandom_range(0, 255);
    gap   = $urandom_range(0, 15);
    mode  = $urandom_range(0, 1);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; len = '0; gap = '0; mode = 1'b0; out_ready = 1'b0;
    #1;
    checks++;
    if ({out_valid, busy, done, beat_cnt, out_data} !== 43'd0) begin
      errors++;
      $display("FAIL reset_vals: valid=%b busy=%b done=%b beat=%0d data=%h, expected all 0",
               out_valid, busy, done, beat_cnt, out_data);
    end
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: valid=%b busy=%b done=%b, expected 0 0 0",
               out_valid, busy, done);
    end
  endtask

  task automatic test_count_burst();
    out_ready = 1'b1;
    do_start(8'd4, 4'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 || busy !== 1'b1 || out_data !== 32'(i) || done !== 1'b0) begin
        errors++;
        $display("FAIL count_beat%0d: valid=%b busy=%b done=%b data=%h, expected 1 1 0 %h",
                 i, out_valid, busy, done, out_data, 32'(i));
      end
      tick();
    end
    checks++;
    if (done !== 1'b1 || out_valid !== 1'b0 || beat_cnt !== 8'd4) begin
      errors++;
      $display("FAIL count_done: done=%b valid=%b beat=%0d, expected 1 0 4",
               done, out_valid, beat_cnt);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || beat_cnt !== 8'd4) begin
      errors++;
      $display("FAIL count_idle: done=%b busy=%b beat=%0d, expected 0 0 4",
               done, busy, beat_cnt);
    end
  endtask

  task automatic test_gap();
    bit pat [7] = '{1, 0, 0, 1, 0, 0, 1};
    out_ready = 1'b1;
    do_start(8'd3, 4'd2, 1'b0);
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (out_valid !== pat[i] || done !== 1'b0) begin
        errors++;
        $display("FAIL gap_cycle%0d: valid=%b done=%b, expected %b 0",
                 i, out_valid, done, pat[i]);
      end
      tick();
    end
    checks++;
    if (done !== 1'b1 || beat_cnt !== 8'd3) begin
      errors++;
      $display("FAIL gap_done: done=%b beat=%0d, expected 1 3", done, beat_cnt);
    end
    tick();
  endtask

  task automatic test_lfsr();
    logic [31:0] exp_w;
    exp_w = 32'h0000_0001;
    out_ready = 1'b1;
    do_start(8'd3, 4'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_w) begin
        errors++;
        $display("FAIL lfsr_word%0d: valid=%b data=%h, expected 1 %h",
                 i, out_valid, out_data, exp_w);
      end
      if (i == 1) begin
        checks++;
        if (exp_w !== 32'h8020_0003 || out_data !== 32'h8020_0003) begin
          errors++;
          $display("FAIL lfsr_second: data=%h, expected 80200003", out_data);
        end
      end
      exp_w = ref_lfsr(exp_w);
      tick();
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL lfsr_done: done=%b, expected 1", done);
    end
    tick();
  endtask

  task automatic test_stall();
    out_ready = 1'b1;
    do_start(8'd4, 4'd0, 1'b0);
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'd1 || beat_cnt !== 8'd1) begin
        errors++;
        $display("FAIL stall_hold%0d: valid=%b data=%h beat=%0d, expected 1 1 1",
                 i, out_valid, out_data, beat_cnt);
      end
      tick();
    end
    out_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'(i)) begin
        errors++;
        $display("FAIL stall_resume%0d: valid=%b data=%h, expected 1 %h",
                 i, out_valid, out_data, 32'(i));
      end
      tick();
    end
    checks++;
    if (done !== 1'b1 || beat_cnt !== 8'd4) begin
      errors++;
      $display("FAIL stall_done: done=%b beat=%0d, expected 1 4", done, beat_cnt);
    end
    tick();
  endtask

  // Four-entry buffer sink: fills, stalls the source while full, then drains
  task automatic test_fifo_sink();
    logic [31:0] fifo[$];
    int          n;
    fifo.delete();
    out_ready = 1'b1;
    do_start(8'd6, 4'd0, 1'b0);
    n = 0;
    while (fifo.size() < 4 && n < 50) begin
      out_ready = 1'b1;
      if (out_valid) fifo.push_back(out_data);
      tick();
      n++;
    end
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'd4) begin
        errors++;
        $display("FAIL sink_full_stall%0d: valid=%b data=%h, expected 1 4",
                 i, out_valid, out_data);
      end
      tick();
    end
    out_ready = 1'b1;
    n = 0;
    while (!done && n < 50) begin
      if (out_valid) fifo.push_back(out_data);
      tick();
      n++;
    end
    checks++;
    if (fifo.size() != 6) begin
      errors++;
      $display("FAIL sink_count: got %0d words, expected 6", fifo.size());
    end
    for (int i = 0; i < 6 && fifo.size() > 0; i++) begin
      logic [31:0] w;
      w = fifo.pop_front();
      checks++;
      if (w !== 32'(i)) begin
        errors++;
        $display("FAIL sink_order%0d: got %h, expected %h", i, w, 32'(i));
      end
    end
    tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    do_start(8'd8, 4'd0, 1'b0);
    tick();
    out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || beat_cnt !== 8'd0 ||
        out_data !== 32'd0) begin
      errors++;
      $display("FAIL rst_async: valid=%b busy=%b done=%b beat=%0d data=%h, expected 0s",
               out_valid, busy, done, beat_cnt, out_data);
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (done !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL rst_no_done%0d: done=%b valid=%b, expected 0 0", i, done, out_valid);
      end
    end
    out_ready = 1'b1;
    do_start(8'd2, 4'd0, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'd0) begin
      errors++;
      $display("FAIL rst_restart: valid=%b data=%h, expected 1 0", out_valid, out_data);
    end
    tick(); tick(); tick();
  endtask

  task automatic test_start_busy();
    out_ready = 1'b0;
    do_start(8'd3, 4'd0, 1'b0);
    start = 1'b1; len = 8'd9; gap = 4'd5; mode = 1'b1;
    tick();
    start = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'(i)) begin
        errors++;
        $display("FAIL busy_start_word%0d: valid=%b data=%h, expected 1 %h",
                 i, out_valid, out_data, 32'(i));
      end
      tick();
    end
    checks++;
    if (done !== 1'b1 || beat_cnt !== 8'd3) begin
      errors++;
      $display("FAIL busy_start_done: done=%b beat=%0d, expected 1 3", done, beat_cnt);
    end
    tick();
  endtask

  task automatic test_len_zero();
    out_ready = 1'b1;
    do_start(8'd0, 4'd3, 1'b0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b0 || beat_cnt !== 8'd0) begin
      errors++;
      $display("FAIL len0_done: done=%b busy=%b valid=%b beat=%0d, expected 1 1 0 0",
               done, busy, out_valid, beat_cnt);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL len0_idle: done=%b busy=%b valid=%b, expected 0 0 0",
               done, busy, out_valid);
    end
  endtask

  task automatic test_max_len();
    int bad;
    bad = 0;
    out_ready = 1'b1;
    do_start(8'd255, 4'd0, 1'b0);
    for (int i = 0; i < 255; i++) begin
      if (out_valid !== 1'b1 || out_data !== 32'(i) || done !== 1'b0) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL maxlen_beats: %0d bad beats, expected 0", bad);
    end
    checks++;
    if (done !== 1'b1 || beat_cnt !== 8'd255) begin
      errors++;
      $display("FAIL maxlen_done: done=%b beat=%0d, expected 1 255", done, beat_cnt);
    end
    tick();
  endtask

  // Random bursts with random ready; model tracks expected word, beat count and gap
  task automatic test_random(input int nburst);
    for (int b = 0; b < nburst; b++) begin
      int          l, g, got, gap_left, cyc;
      logic        m, r;
      logic [31:0] exp_w;
      l = $urandom_range(0, 12);
      g = $urandom_range(0, 3);
      m = 1'($urandom_range(0, 1));
      exp_w = m ? 32'h0000_0001 : 32'd0;
      got = 0;
      gap_left = 0;
      cyc = 0;
      out_ready = 1'($urandom_range(0, 1));
      do_start(8'(l), 4'(g), m);
      while (1) begin
        if (cyc > 400) begin
          checks++;
          errors++;
          $display("FAIL rand_timeout: burst %0d stuck after %0d beats of %0d", b, got, l);
          break;
        end
        if (got == l) begin
          checks++;
          if (done !== 1'b1 || out_valid !== 1'b0 || beat_cnt !== 8'(l)) begin
            errors++;
            $display("FAIL rand_done: burst %0d done=%b valid=%b beat=%0d, expected 1 0 %0d",
                     b, done, out_valid, beat_cnt, l);
          end
          tick();
          break;
        end
        if (gap_left > 0) begin
          checks++;
          if (out_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL rand_gap: burst %0d valid=%b busy=%b, expected 0 1",
                     b, out_valid, busy);
          end
          gap_left--;
          out_ready = 1'($urandom_range(0, 1));
          tick();
          cyc++;
          continue;
        end
        checks++;
        if (out_valid !== 1'b1 || out_data !== exp_w || done !== 1'b0 ||
            beat_cnt !== 8'(got)) begin
          errors++;
          $display("FAIL rand_beat: burst %0d beat %0d valid=%b data=%h done=%b cnt=%0d, expected 1 %h 0 %0d",
                   b, got, out_valid, out_data, done, beat_cnt, exp_w, got);
        end
        r = 1'($urandom_range(0, 1));
        out_ready = r;
        tick();
        cyc++;
        if (r) begin
          got++;
          exp_w = m ? ref_lfsr(exp_w) : exp_w + 32'd1;
          gap_left = (got < l) ? g : 0;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_count_burst();
    test_gap();
    test_lfsr();
    test_stall();
    test_fifo_sink();
    test_reset_mid();
    test_start_busy();
    test_len_zero();
    test_max_len();
    test_random(40);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
